// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port synchronous memory
// between NUM_REQ requesters: IDLE -> CMD (-> RD_WAIT for reads) -> IDLE.
module mem_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      mem_en,
    output logic                      mem_wr_rd,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wr_data,
    input  logic [DATA_W-1:0]         mem_rd_data,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_owner;

    logic               w_found;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_ptr_next;
    logic [NUM_REQ-1:0] w_onehot;

    // Round-robin search: first set req bit at or above r_ptr, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_found  = 1'b0;
        w_idx    = '0;
        w_win    = '0;
        w_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        w_onehot[w_win] = 1'b1;
        w_ptr_next = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: clearing r_state here is what discards a read caught in RD_WAIT.
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            mem_en      <= 1'b0;
            mem_wr_rd   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            busy        <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= only, so every read in this block sees pre-edge values.
            gnt       <= '0;
            rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state     <= CMD;
                        r_owner     <= w_win;
                        r_ptr       <= w_ptr_next;
                        gnt         <= w_onehot;
                        mem_en      <= 1'b1;
                        mem_wr_rd   <= req_wr[w_win];
                        mem_addr    <= req_addr[int'(w_win)*ADDR_W +: ADDR_W];
                        mem_wr_data <= req_wdata[int'(w_win)*DATA_W +: DATA_W];
                        busy        <= 1'b1;
                    end else begin
                        mem_en <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                CMD: begin
                    // mem_wr_rd still holds the granted operation here.
                    mem_en    <= 1'b0;
                    mem_wr_rd <= 1'b0;
                    if (mem_wr_rd) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= RD_WAIT;
                        busy    <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    rsp_data           <= mem_rd_data;
                    rsp_valid[r_owner] <= 1'b1;
                    r_state            <= IDLE;
                    busy               <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
